// File: rtl/control_programacion_registros_pkg.sv
// Shared constants for the register-bank configuration sequencer:
// group codes, field indices, field limits, FSM state encodings and the
// group/field stepping helpers. Limits are plain binary values.
package control_programacion_registros_pkg;

  // Register-group codes driven on funcion_conf (chip-select decoder input)
  localparam logic [1:0] GRP_NINGUNO = 2'b00;
  localparam logic [1:0] GRP_HORA    = 2'b01;
  localparam logic [1:0] GRP_FECHA   = 2'b10;
  localparam logic [1:0] GRP_TIMER   = 2'b11;

  // Field indices within a group; index 3 is never produced
  localparam logic [1:0] CAMPO_SEG_DIA   = 2'd0;
  localparam logic [1:0] CAMPO_MIN_MES   = 2'd1;
  localparam logic [1:0] CAMPO_HORA_JAHR = 2'd2;

  // Inclusive field limits
  localparam int unsigned LIM_CERO     = 32'd0;
  localparam int unsigned LIM_SEG_MAX  = 32'd59;
  localparam int unsigned LIM_MIN_MAX  = 32'd59;
  localparam int unsigned LIM_HORA_MAX = 32'd23;
  localparam int unsigned LIM_DIA_MIN  = 32'd1;
  localparam int unsigned LIM_DIA_MAX  = 32'd31;
  localparam int unsigned LIM_MES_MIN  = 32'd1;
  localparam int unsigned LIM_MES_MAX  = 32'd12;
  localparam int unsigned LIM_JAHR_MAX = 32'd99;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    CARGA   = 2'b01,
    EDITA   = 2'b10,
    ESCRIBE = 2'b11
  } estado_t;

  // Group rotation 01 -> 10 -> 11 -> 01; anything else restarts at hora
  function automatic logic [1:0] siguiente_grupo(input logic [1:0] grupo);
    case (grupo)
      GRP_HORA:  siguiente_grupo = GRP_FECHA;
      GRP_FECHA: siguiente_grupo = GRP_TIMER;
      GRP_TIMER: siguiente_grupo = GRP_HORA;
      default:   siguiente_grupo = GRP_HORA;
    endcase
  endfunction

  // Field rotation forwards 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] siguiente_campo(input logic [1:0] campo);
    case (campo)
      CAMPO_SEG_DIA: siguiente_campo = CAMPO_MIN_MES;
      CAMPO_MIN_MES: siguiente_campo = CAMPO_HORA_JAHR;
      default:       siguiente_campo = CAMPO_SEG_DIA;
    endcase
  endfunction

  // Field rotation backwards 0 -> 2 -> 1 -> 0
  function automatic logic [1:0] anterior_campo(input logic [1:0] campo);
    case (campo)
      CAMPO_SEG_DIA:   anterior_campo = CAMPO_HORA_JAHR;
      CAMPO_HORA_JAHR: anterior_campo = CAMPO_MIN_MES;
      default:         anterior_campo = CAMPO_SEG_DIA;
    endcase
  endfunction

endpackage

// File: rtl/control_programacion_registros_limites.sv
// limites_campo: combinational lookup of the inclusive [min,max] range of
// the field selected by (funcion_conf, campo_sel).
//   funcion_conf : group code
//   campo_sel    : field index within the group
//   valor_min    : smallest legal value of the field
//   valor_max    : largest legal value of the field
// Unused combinations (group 00, field 3) report [0,0].
module limites_campo
  import control_programacion_registros_pkg::*;
#(
  parameter int ANCHO_DATO = 8
) (
  input  logic [1:0]            funcion_conf,
  input  logic [1:0]            campo_sel,
  output logic [ANCHO_DATO-1:0] valor_min,
  output logic [ANCHO_DATO-1:0] valor_max
);

  // Range table; hora and timer groups share the same time-of-day limits
  always_comb begin
    valor_min = ANCHO_DATO'(LIM_CERO);
    valor_max = ANCHO_DATO'(LIM_CERO);
    case (funcion_conf)
      GRP_HORA, GRP_TIMER: begin
        case (campo_sel)
          CAMPO_SEG_DIA:   valor_max = ANCHO_DATO'(LIM_SEG_MAX);
          CAMPO_MIN_MES:   valor_max = ANCHO_DATO'(LIM_MIN_MAX);
          CAMPO_HORA_JAHR: valor_max = ANCHO_DATO'(LIM_HORA_MAX);
          default:         valor_max = ANCHO_DATO'(LIM_CERO);
        endcase
      end
      GRP_FECHA: begin
        case (campo_sel)
          CAMPO_SEG_DIA: begin
            valor_min = ANCHO_DATO'(LIM_DIA_MIN);
            valor_max = ANCHO_DATO'(LIM_DIA_MAX);
          end
          CAMPO_MIN_MES: begin
            valor_min = ANCHO_DATO'(LIM_MES_MIN);
            valor_max = ANCHO_DATO'(LIM_MES_MAX);
          end
          CAMPO_HORA_JAHR: valor_max = ANCHO_DATO'(LIM_JAHR_MAX);
          default:         valor_max = ANCHO_DATO'(LIM_CERO);
        endcase
      end
      default: begin
        valor_min = ANCHO_DATO'(LIM_CERO);
        valor_max = ANCHO_DATO'(LIM_CERO);
      end
    endcase
  end

endmodule

// File: rtl/control_programacion_registros.sv
// Configuration sequencer for the clock/date/timer register bank.
// Button pulses select a register group and field, the field value is
// loaded, stepped up/down with wrap inside its range, and written back
// with a one-cycle strobe.
//   clk, reset   : clock, synchronous active-low reset
//   sw_prog      : programming-mode enable (level)
//   btn_*        : debounced one-cycle button pulses
//   dato_actual  : current value of the selected field (external mux)
//   funcion_conf : selected group (00 none, 01 hora, 10 fecha, 11 timer)
//   campo_sel    : selected field within the group
//   dato_conf    : value being edited
//   escribir     : one-cycle write strobe, dato_conf valid alongside
module control_programacion_registros
  import control_programacion_registros_pkg::*;
#(
  parameter int ANCHO_DATO = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_prog,
  input  logic                  btn_modo,
  input  logic                  btn_der,
  input  logic                  btn_izq,
  input  logic                  btn_arriba,
  input  logic                  btn_abajo,
  input  logic [ANCHO_DATO-1:0] dato_actual,
  output logic [1:0]            funcion_conf,
  output logic [1:0]            campo_sel,
  output logic [ANCHO_DATO-1:0] dato_conf,
  output logic                  escribir
);

  localparam logic [ANCHO_DATO-1:0] UNO = ANCHO_DATO'(1);

  estado_t               estado_r;
  logic [1:0]            funcion_r;
  logic [1:0]            campo_r;
  logic [ANCHO_DATO-1:0] dato_r;
  logic                  escribir_r;

  logic [ANCHO_DATO-1:0] lim_min_s;
  logic [ANCHO_DATO-1:0] lim_max_s;
  logic [ANCHO_DATO-1:0] dato_carga_s;
  logic [ANCHO_DATO-1:0] dato_inc_s;
  logic [ANCHO_DATO-1:0] dato_dec_s;

  limites_campo #(
    .ANCHO_DATO (ANCHO_DATO)
  ) u_limites (
    .funcion_conf (funcion_r),
    .campo_sel    (campo_r),
    .valor_min    (lim_min_s),
    .valor_max    (lim_max_s)
  );

  // Loaded value is forced to the field minimum when out of range
  always_comb begin
    dato_carga_s = dato_actual;
    if ((dato_actual < lim_min_s) || (dato_actual > lim_max_s)) begin
      dato_carga_s = lim_min_s;
    end else begin
      dato_carga_s = dato_actual;
    end
  end

  // Wrap-around step; >= / <= keep a stray value from escaping the range
  always_comb begin
    dato_inc_s = dato_r + UNO;
    dato_dec_s = dato_r - UNO;
    if (dato_r >= lim_max_s) begin
      dato_inc_s = lim_min_s;
    end else begin
      dato_inc_s = dato_r + UNO;
    end
    if (dato_r <= lim_min_s) begin
      dato_dec_s = lim_max_s;
    end else begin
      dato_dec_s = dato_r - UNO;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_r   <= REPOSO;
      funcion_r  <= GRP_NINGUNO;
      campo_r    <= CAMPO_SEG_DIA;
      dato_r     <= '0;
      escribir_r <= 1'b0;
    end else begin
      case (estado_r)
        REPOSO: begin
          escribir_r <= 1'b0;
          dato_r     <= '0;
          campo_r    <= CAMPO_SEG_DIA;
          if (sw_prog) begin
            funcion_r <= GRP_HORA;
            estado_r  <= CARGA;
          end else begin
            funcion_r <= GRP_NINGUNO;
            estado_r  <= REPOSO;
          end
        end
        CARGA: begin
          escribir_r <= 1'b0;
          dato_r     <= dato_carga_s;
          estado_r   <= EDITA;
        end
        EDITA: begin
          escribir_r <= 1'b0;
          // Only the highest-priority pulse of the cycle takes effect
          if (!sw_prog) begin
            estado_r  <= REPOSO;
            funcion_r <= GRP_NINGUNO;
            campo_r   <= CAMPO_SEG_DIA;
            dato_r    <= '0;
          end else if (btn_modo) begin
            funcion_r <= siguiente_grupo(funcion_r);
            campo_r   <= CAMPO_SEG_DIA;
            estado_r  <= CARGA;
          end else if (btn_der) begin
            campo_r  <= siguiente_campo(campo_r);
            estado_r <= CARGA;
          end else if (btn_izq) begin
            campo_r  <= anterior_campo(campo_r);
            estado_r <= CARGA;
          end else if (btn_arriba ^ btn_abajo) begin
            dato_r     <= btn_arriba ? dato_inc_s : dato_dec_s;
            escribir_r <= 1'b1;
            estado_r   <= ESCRIBE;
          end else begin
            estado_r <= EDITA;
          end
        end
        ESCRIBE: begin
          // Strobe always completes; sw_prog is honoured back in EDITA
          escribir_r <= 1'b0;
          estado_r   <= EDITA;
        end
        default: begin
          estado_r   <= REPOSO;
          funcion_r  <= GRP_NINGUNO;
          campo_r    <= CAMPO_SEG_DIA;
          dato_r     <= '0;
          escribir_r <= 1'b0;
        end
      endcase
    end
  end

  assign funcion_conf = funcion_r;
  assign campo_sel    = campo_r;
  assign dato_conf    = dato_r;
  assign escribir     = escribir_r;

endmodule

// File: tb/tb_control_programacion_registros.sv
// Self-checking bench for control_programacion_registros. Expected write
// transactions are queued when an up/down pulse is driven and compared
// when the strobe appears; state/field/value checks are done per scenario.
module tb_control_programacion_registros;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sw_prog;
  logic         btn_modo;
  logic         btn_der;
  logic         btn_izq;
  logic         btn_arriba;
  logic         btn_abajo;
  logic [W-1:0] dato_actual;
  logic [1:0]   funcion_conf;
  logic [1:0]   campo_sel;
  logic [W-1:0] dato_conf;
  logic         escribir;

  typedef struct packed {
    logic [1:0]   f;
    logic [1:0]   c;
    logic [W-1:0] d;
  } esc_t;

  esc_t esperado_q[$];
  esc_t exp_e;
  esc_t got_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_esc = 1'b0;

  control_programacion_registros #(.ANCHO_DATO(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_prog      (sw_prog),
    .btn_modo     (btn_modo),
    .btn_der      (btn_der),
    .btn_izq      (btn_izq),
    .btn_arriba   (btn_arriba),
    .btn_abajo    (btn_abajo),
    .dato_actual  (dato_actual),
    .funcion_conf (funcion_conf),
    .campo_sel    (campo_sel),
    .dato_conf    (dato_conf),
    .escribir     (escribir)
  );

  always #5 clk = ~clk;

  // One clock edge, then sample 1 time unit later and service the scoreboard
  task automatic tick();
    @(posedge clk);
    #1;
    if (escribir === 1'b1) begin
      checks++;
      if (prev_esc) begin
        errors++;
        $display("FAIL strobe_width escribir=1 on consecutive cycles, required single-cycle pulse");
      end
      checks++;
      got_e = {funcion_conf, campo_sel, dato_conf};
      if (esperado_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got f=%0d c=%0d d=%0d required no write",
                 funcion_conf, campo_sel, dato_conf);
      end else begin
        exp_e = esperado_q.pop_front();
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL write_data got f=%0d c=%0d d=%0d required f=%0d c=%0d d=%0d",
                   got_e.f, got_e.c, got_e.d, exp_e.f, exp_e.c, exp_e.d);
        end
      end
    end
    prev_esc = (escribir === 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse buttons for one cycle: {modo, der, izq, arriba, abajo}
  task automatic press(input logic [4:0] b);
    {btn_modo, btn_der, btn_izq, btn_arriba, btn_abajo} = b;
    tick();
    {btn_modo, btn_der, btn_izq, btn_arriba, btn_abajo} = 5'b00000;
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sw_prog = 1'b0; dato_actual = 8'd0;
    {btn_modo, btn_der, btn_izq, btn_arriba, btn_abajo} = 5'b00000;
    idle(2);
    checks++;
    if ({funcion_conf, campo_sel, dato_conf, escribir} !== {2'b00, 2'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got f=%0d c=%0d d=%0d e=%0b required 0 0 0 0",
               funcion_conf, campo_sel, dato_conf, escribir);
    end
    reset = 1'b1;
    idle(1);
    chk("idle_no_prog_f", int'(funcion_conf), 0);
  endtask

  task automatic test_entrada();
    dato_actual = 8'd37;
    sw_prog = 1'b1;
    tick();
    chk("entry_f", int'(funcion_conf), 1);
    chk("entry_c", int'(campo_sel), 0);
    tick();
    chk("entry_load", int'(dato_conf), 37);
  endtask

  task automatic test_hora_wrap();
    dato_actual = 8'd23;
    press(5'b01000); tick();
    press(5'b01000); tick();
    chk("hora_campo2", int'(campo_sel), 2);
    chk("hora_load23", int'(dato_conf), 23);
    esperado_q.push_back({2'b01, 2'd2, 8'd0});
    press(5'b00010);
    chk("hora_inc_strobe", int'(escribir), 1);
    tick();
    chk("hora_inc_wrap", int'(dato_conf), 0);
    chk("hora_strobe_end", int'(escribir), 0);
    esperado_q.push_back({2'b01, 2'd2, 8'd23});
    press(5'b00001); tick();
    chk("hora_dec_wrap", int'(dato_conf), 23);
  endtask

  task automatic test_fecha();
    dato_actual = 8'd1;
    press(5'b10000); tick();
    chk("fecha_f", int'(funcion_conf), 2);
    chk("fecha_dia_load", int'(dato_conf), 1);
    press(5'b01000); tick();
    chk("fecha_campo_mes", int'(campo_sel), 1);
    esperado_q.push_back({2'b10, 2'd1, 8'd12});
    press(5'b00001); tick();
    chk("mes_dec_wrap", int'(dato_conf), 12);
    dato_actual = 8'd0;
    press(5'b00100); tick();
    chk("dia_campo0", int'(campo_sel), 0);
    chk("dia_clamp_low", int'(dato_conf), 1);
    dato_actual = 8'd200;
    press(5'b00100); tick();
    chk("izq_0_to_2", int'(campo_sel), 2);
    chk("jahr_clamp_high", int'(dato_conf), 0);
    dato_actual = 8'd12;
    press(5'b00100); tick();
    chk("mes_load12", int'(dato_conf), 12);
    esperado_q.push_back({2'b10, 2'd1, 8'd1});
    press(5'b00010); tick();
    chk("mes_inc_wrap", int'(dato_conf), 1);
  endtask

  task automatic test_modo_ciclo();
    int g;
    g = 2;
    for (int k = 0; k < 5; k++) begin
      g = (g == 3) ? 1 : g + 1;
      press(5'b10000);
      chk("modo_seq_f", int'(funcion_conf), g);
      chk("modo_seq_c", int'(campo_sel), 0);
      tick();
    end
    press(5'b00100);
    chk("hora_izq_0_to_2", int'(campo_sel), 2);
    tick();
  endtask

  task automatic test_simultaneo();
    // modo beats arriba: group advances and no write is expected
    press(5'b10010);
    chk("sim_modo_f", int'(funcion_conf), 2);
    chk("sim_modo_c", int'(campo_sel), 0);
    tick();
    chk("sim_dia_load", int'(dato_conf), 12);
    press(5'b00011); idle(2);
    chk("sim_both_hold", int'(dato_conf), 12);
    press(5'b01010);
    chk("sim_der_c", int'(campo_sel), 1);
    tick();
  endtask

  task automatic test_timer();
    dato_actual = 8'd59;
    press(5'b10000); tick();
    chk("timer_f", int'(funcion_conf), 3);
    chk("timer_load", int'(dato_conf), 59);
    esperado_q.push_back({2'b11, 2'd0, 8'd0});
    press(5'b00010); tick();
    esperado_q.push_back({2'b11, 2'd0, 8'd59});
    press(5'b00001); tick();
    chk("timer_dec_wrap", int'(dato_conf), 59);
  endtask

  task automatic test_reset_escribe();
    esperado_q.push_back({2'b11, 2'd0, 8'd0});
    btn_arriba = 1'b1;
    tick();
    btn_arriba = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if ({funcion_conf, campo_sel, dato_conf, escribir} !== {2'b00, 2'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got f=%0d c=%0d d=%0d e=%0b required 0 0 0 0",
               funcion_conf, campo_sel, dato_conf, escribir);
    end
    reset = 1'b1;
  endtask

  task automatic test_sw_prog();
    idle(2);
    chk("reentry_load", int'(dato_conf), 59);
    sw_prog = 1'b0;
    tick();
    chk("exit_f", int'(funcion_conf), 0);
    chk("exit_d", int'(dato_conf), 0);
    sw_prog = 1'b1;
    idle(2);
    esperado_q.push_back({2'b01, 2'd0, 8'd0});
    btn_arriba = 1'b1;
    tick();
    btn_arriba = 1'b0;
    sw_prog = 1'b0;
    tick();
    chk("sw_off_escribe_f", int'(funcion_conf), 1);
    chk("sw_off_escribe_e", int'(escribir), 0);
    tick();
    chk("sw_off_then_exit_f", int'(funcion_conf), 0);
  endtask

  initial begin
    test_reset();
    test_entrada();
    test_hora_wrap();
    test_fecha();
    test_modo_ciclo();
    test_simultaneo();
    test_timer();
    test_reset_escribe();
    test_sw_prog();
    idle(3);
    chk("queue_drained", esperado_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
